// File: rtl/step_counter_if.sv
// Load/step controls and count output shared between step_counter and whoever drives it.
interface step_counter_if #(
    parameter int WIDTH   = 8,
    parameter int DELTA_W = 4
);
    logic               preload;
    logic               up_dn;
    logic [DELTA_W-1:0] delta;
    logic [WIDTH-1:0]   pl_data;
    logic [WIDTH-1:0]   qout;

    modport master (
        output preload,
        output up_dn,
        output delta,
        output pl_data,
        input  qout
    );

    modport slave (
        input  preload,
        input  up_dn,
        input  delta,
        input  pl_data,
        output qout
    );
endinterface

// File: rtl/step_counter.sv
// Up/down counter stepping by a programmable delta each clock, with synchronous preload.
// Preload wins over counting; arithmetic wraps modulo 2^WIDTH with no carry or borrow output.
module step_counter #(
    parameter int WIDTH   = 8,
    parameter int DELTA_W = 4
) (
    input  logic          clk,
    input  logic          reset,
    step_counter_if.slave bus
);
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] count_next;

    // delta is unsigned; widen with zeros before the add/subtract
    assign step = {{(WIDTH-DELTA_W){1'b0}}, bus.delta};

    always_comb begin
        count_next = count;
        if (bus.preload) begin
            count_next = bus.pl_data;
        end else if (bus.up_dn) begin
            count_next = count + step;
        end else begin
            count_next = count - step;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    assign bus.qout = count;
endmodule

// File: tb/tb_step_counter.sv
// Directed bench for step_counter: expected counts are queued as stimulus is issued
// and a monitor compares them against qout just after each rising edge.
module tb_step_counter;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    logic [7:0] exp_q[$];
    string      name_q[$];
    logic [7:0] m;

    step_counter_if #(.WIDTH(8), .DELTA_W(4)) bus ();

    step_counter #(.WIDTH(8), .DELTA_W(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one vector at the falling edge; its result is due at the next rising edge.
    task automatic drive(input logic rst, input logic pre, input logic ud,
                         input logic [3:0] d, input logic [7:0] pl,
                         input logic [7:0] exp, input string nm);
        @(negedge clk);
        reset       = rst;
        bus.preload = pre;
        bus.up_dn   = ud;
        bus.delta   = d;
        bus.pl_data = pl;
        exp_q.push_back(exp);
        name_q.push_back(nm);
    endtask

    task automatic check_now(input logic [7:0] exp, input string nm);
        vectors++;
        if (bus.qout !== exp) begin
            miscompares++;
            $display("FAIL %s: qout=%0d expected=%0d at %0t", nm, bus.qout, exp, $time);
        end
    endtask

    initial begin : monitor
        logic [7:0] e;
        string      nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                vectors++;
                if (bus.qout !== e) begin
                    miscompares++;
                    $display("FAIL %s: qout=%0d expected=%0d at %0t", nm, bus.qout, e, $time);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        bus.preload = 1'b0;
        bus.up_dn   = 1'b1;
        bus.delta   = 4'd2;
        bus.pl_data = 8'h00;
        #1;
        check_now(8'd0, "reset_async_clear");

        // reset held: inputs asking to count and load must be ignored
        drive(1'b0, 1'b0, 1'b1, 4'd2, 8'h00, 8'd0, "reset_hold0");
        drive(1'b0, 1'b1, 1'b1, 4'd2, 8'h33, 8'd0, "reset_hold1");
        drive(1'b0, 1'b0, 1'b1, 4'd2, 8'h00, 8'd0, "reset_hold2");

        // release and count up by 2 for 30 edges
        m = 8'd0;
        for (int i = 0; i < 30; i++) begin
            m = m + 8'd2;
            drive(1'b1, 1'b0, 1'b1, 4'd2, 8'h00, m, "up_by_2");
        end
        drive(1'b1, 1'b0, 1'b1, 4'd0, 8'h00, 8'd60, "up_30_edges_is_60");

        // preload 245 then wrap past 255
        drive(1'b1, 1'b1, 1'b1, 4'd2, 8'd245, 8'd245, "preload_245");
        drive(1'b1, 1'b0, 1'b1, 4'd2, 8'd0, 8'd247, "up_wrap_247");
        drive(1'b1, 1'b0, 1'b1, 4'd2, 8'd0, 8'd249, "up_wrap_249");
        drive(1'b1, 1'b0, 1'b1, 4'd2, 8'd0, 8'd251, "up_wrap_251");
        drive(1'b1, 1'b0, 1'b1, 4'd2, 8'd0, 8'd253, "up_wrap_253");
        drive(1'b1, 1'b0, 1'b1, 4'd2, 8'd0, 8'd255, "up_wrap_255");
        drive(1'b1, 1'b0, 1'b1, 4'd2, 8'd0, 8'd1,   "up_wrap_1");
        drive(1'b1, 1'b0, 1'b1, 4'd2, 8'd0, 8'd3,   "up_wrap_3");

        // preload 15 then count down by 2 across zero
        drive(1'b1, 1'b1, 1'b0, 4'd2, 8'd15, 8'd15, "preload_15");
        m = 8'd15;
        for (int i = 0; i < 30; i++) begin
            m = m - 8'd2;
            drive(1'b1, 1'b0, 1'b0, 4'd2, 8'd0, m, "down_by_2");
        end
        drive(1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 8'd211, "down_30_edges_is_211");

        // preload beats a pending step
        drive(1'b1, 1'b1, 1'b1, 4'd7, 8'h80, 8'h80, "preload_priority");
        drive(1'b1, 1'b0, 1'b1, 4'd7, 8'h00, 8'h87, "step_after_preload");

        // delta=0 holds in both directions
        for (int i = 0; i < 5; i++)
            drive(1'b1, 1'b0, i[0], 4'd0, 8'hff, 8'h87, "delta0_hold");

        // full step size wraps both ways
        drive(1'b1, 1'b1, 1'b1, 4'd15, 8'd250, 8'd250, "preload_250");
        drive(1'b1, 1'b0, 1'b1, 4'd15, 8'd0,   8'd9,   "up15_from_250");
        drive(1'b1, 1'b1, 1'b0, 4'd15, 8'd3,   8'd3,   "preload_3");
        drive(1'b1, 1'b0, 1'b0, 4'd15, 8'd0,   8'd244, "down15_from_3");

        // count a bit, then assert reset between edges
        drive(1'b1, 1'b0, 1'b1, 4'd5, 8'd0, 8'd249, "up5_249");
        drive(1'b1, 1'b1, 1'b1, 4'd5, 8'h55, 8'h55, "preload_55");
        @(negedge clk);
        bus.preload = 1'b1;
        bus.pl_data = 8'hAA;
        #2;
        reset = 1'b0;
        #1;
        check_now(8'd0, "midcycle_async_reset");
        drive(1'b0, 1'b1, 1'b1, 4'd5, 8'hAA, 8'd0, "reset_discards_preload");
        drive(1'b0, 1'b0, 1'b1, 4'd5, 8'h00, 8'd0, "reset_low_hold");
        drive(1'b1, 1'b0, 1'b1, 4'd3, 8'h00, 8'd3, "resume_3");
        drive(1'b1, 1'b0, 1'b1, 4'd3, 8'h00, 8'd6, "resume_6");

        // drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 5 && exp_q.size() > 0; i++)
            @(posedge clk);
        @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: pending=%0d expected=0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
